// File: rtl/apb_mem_bridge_pkg.sv
// Shared types for the APB-to-memory-request bridge.
package apb_mem_bridge_pkg;

  // Widest data path any instance may use; the response record is sized to it.
  localparam int unsigned MaxDataW = 64;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReq     = 3'd1,
    StWaitAck = 3'd2,
    StResp    = 3'd3,
    StDrain   = 3'd4
  } state_t;

  typedef struct packed {
    logic                err;
    logic [MaxDataW-1:0] data;
  } resp_t;

  // Zero-extend a core read word into the response record data field.
  function automatic logic [MaxDataW-1:0] widen_data(input logic [MaxDataW-1:0] d);
    return d;
  endfunction

endpackage

// File: rtl/apb_mem_bridge_wdt.sv
// Saturating response-timeout counter for the bridge.
module bridge_wdt #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  if (TIMEOUT == 0) begin : g_off
    // Timeout disabled: the counter does not exist.
    logic unused_off;
    assign unused_off = ^{clock, reset, clear_i, enable_i};
    assign expired_o  = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, then increment until the limit and hold there.
    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (enable_i && (cnt_q != Limit)) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    // Counter register.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired_o = (cnt_q == Limit);
  end

endmodule

// File: rtl/apb_mem_bridge.sv
// APB slave that turns each access into one accept/ack memory request, with window and
// privilege checks, a response timeout and a registered APB response path.
module apb_mem_bridge
  import apb_mem_bridge_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE      = 32'ha000_0000,
  parameter logic [ADDR_W-1:0] SIZE      = 32'h0200_0000,
  parameter int unsigned       TIMEOUT   = 1024,
  parameter bit                PRIV_ONLY = 1'b0,
  localparam int unsigned      STRB_W    = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] in_paddr,
  input  logic              in_psel,
  input  logic              in_penable,
  input  logic [2:0]        in_pprot,
  input  logic              in_pwrite,
  input  logic [DATA_W-1:0] in_pwdata,
  input  logic [STRB_W-1:0] in_pstrb,
  output logic              in_pready,
  output logic [DATA_W-1:0] in_prdata,
  output logic              in_pslverr,
  output logic [STRB_W-1:0] out_wr,
  output logic              out_rd,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_wdata,
  input  logic              out_accept,
  input  logic              out_ack,
  input  logic              out_error,
  input  logic [DATA_W-1:0] out_rdata
);

  localparam int unsigned       SizeLog2    = $clog2(SIZE);
  localparam logic [ADDR_W-1:0] AddrLowMask = ADDR_W'(STRB_W - 1);

  state_t              state_q, state_d;
  logic                pending_q, pending_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  resp_t               resp_q, resp_d;
  logic                pready_q, pready_d;
  logic                req_rd_q, req_rd_d;
  logic [STRB_W-1:0]   req_wr_q, req_wr_d;

  logic setup;
  logic in_window;
  logic priv_fail;
  logic wdt_clear;
  logic expired;

  assign setup     = in_psel && !in_penable;
  // Window is size-aligned, so only the bits above the window offset matter.
  assign in_window = (in_paddr >> SizeLog2) == (BASE >> SizeLog2);
  assign priv_fail = PRIV_ONLY && !in_pprot[0];

  // Counter runs only while a request is outstanding; it is zero on every entry to REQ.
  assign wdt_clear = !(state_q inside {StReq, StWaitAck});

  bridge_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (wdt_clear),
    .enable_i  (!wdt_clear),
    .expired_o (expired)
  );

  // Next-state, request and response decode.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    resp_d    = '0;
    req_rd_d  = 1'b0;
    req_wr_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (setup) begin
          addr_d  = in_paddr & ~AddrLowMask;
          write_d = in_pwrite;
          wdata_d = in_pwdata;
          strb_d  = in_pstrb;
          if (!in_window || priv_fail) begin
            state_d    = StResp;
            resp_d.err = 1'b1;
          end else if (in_pwrite && (in_pstrb == '0)) begin
            state_d = StResp;
          end else if (pending_q && !out_ack) begin
            // A late ack arriving now settles the debt, so only stall if it has not.
            state_d = StDrain;
          end else begin
            state_d = StReq;
          end
        end
      end

      StDrain: begin
        if (out_ack) begin
          state_d = StReq;
        end
      end

      StReq: begin
        if (out_accept && out_ack) begin
          state_d     = StResp;
          resp_d.err  = out_error;
          resp_d.data = write_q ? '0 : widen_data(MaxDataW'(out_rdata));
        end else if (expired) begin
          state_d    = StResp;
          resp_d.err = 1'b1;
          // Accepted in the expiry cycle: its ack will still come and must be swallowed.
          pending_d  = out_accept;
        end else if (out_accept) begin
          state_d = StWaitAck;
        end
      end

      StWaitAck: begin
        if (out_ack) begin
          state_d     = StResp;
          resp_d.err  = out_error;
          resp_d.data = write_q ? '0 : widen_data(MaxDataW'(out_rdata));
        end else if (expired) begin
          state_d    = StResp;
          resp_d.err = 1'b1;
          pending_d  = 1'b1;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Late acks are absorbed outside the request states and never forwarded.
    if (pending_q && out_ack && (state_q inside {StIdle, StResp, StDrain})) begin
      pending_d = 1'b0;
    end

    // Request lines are registered from the values that will be latched.
    if (state_d == StReq) begin
      req_rd_d = !write_d;
      req_wr_d = write_d ? strb_d : '0;
    end

    pready_d = (state_d == StResp);
  end

  // State, latched access and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      resp_q    <= '0;
      pready_q  <= 1'b0;
      req_rd_q  <= 1'b0;
      req_wr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      resp_q    <= resp_d;
      pready_q  <= pready_d;
      req_rd_q  <= req_rd_d;
      req_wr_q  <= req_wr_d;
    end
  end

  assign in_pready  = pready_q;
  assign in_pslverr = resp_q.err;
  assign in_prdata  = resp_q.data[DATA_W-1:0];
  assign out_rd     = req_rd_q;
  assign out_wr     = req_wr_q;
  assign out_addr   = addr_q;
  assign out_wdata  = wdata_q;

  if (DATA_W < MaxDataW) begin : g_narrow
    logic unused_data;
    assign unused_data = ^resp_q.data[MaxDataW-1:DATA_W];
  end

  logic unused_prot;
  assign unused_prot = ^in_pprot;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Directed self-checking bench for apb_mem_bridge: a 32-bit instance (TIMEOUT=8) and a
// 64-bit privileged-only instance.
module tb_apb_mem_bridge;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: 32-bit data, TIMEOUT=8, no privilege check.
  logic [31:0] a_paddr, a_pwdata, a_prdata, a_out_addr, a_out_wdata, a_rdata;
  logic        a_psel, a_penable, a_pwrite, a_pready, a_pslverr, a_out_rd;
  logic [2:0]  a_pprot;
  logic [3:0]  a_pstrb, a_out_wr;
  logic        a_accept, a_ack, a_error;

  // Instance B: 64-bit data, TIMEOUT=8, privileged-only.
  logic [31:0] b_paddr, b_out_addr;
  logic [63:0] b_pwdata, b_prdata, b_out_wdata, b_rdata;
  logic        b_psel, b_penable, b_pwrite, b_pready, b_pslverr, b_out_rd;
  logic [2:0]  b_pprot;
  logic [7:0]  b_pstrb, b_out_wr;
  logic        b_accept, b_ack, b_error;

  apb_mem_bridge #(
    .DATA_W    (32),
    .TIMEOUT   (8),
    .PRIV_ONLY (1'b0)
  ) u_dut_a (
    .clock      (clock),
    .reset      (reset),
    .in_paddr   (a_paddr),
    .in_psel    (a_psel),
    .in_penable (a_penable),
    .in_pprot   (a_pprot),
    .in_pwrite  (a_pwrite),
    .in_pwdata  (a_pwdata),
    .in_pstrb   (a_pstrb),
    .in_pready  (a_pready),
    .in_prdata  (a_prdata),
    .in_pslverr (a_pslverr),
    .out_wr     (a_out_wr),
    .out_rd     (a_out_rd),
    .out_addr   (a_out_addr),
    .out_wdata  (a_out_wdata),
    .out_accept (a_accept),
    .out_ack    (a_ack),
    .out_error  (a_error),
    .out_rdata  (a_rdata)
  );

  apb_mem_bridge #(
    .DATA_W    (64),
    .TIMEOUT   (8),
    .PRIV_ONLY (1'b1)
  ) u_dut_b (
    .clock      (clock),
    .reset      (reset),
    .in_paddr   (b_paddr),
    .in_psel    (b_psel),
    .in_penable (b_penable),
    .in_pprot   (b_pprot),
    .in_pwrite  (b_pwrite),
    .in_pwdata  (b_pwdata),
    .in_pstrb   (b_pstrb),
    .in_pready  (b_pready),
    .in_prdata  (b_prdata),
    .in_pslverr (b_pslverr),
    .out_wr     (b_out_wr),
    .out_rd     (b_out_rd),
    .out_addr   (b_out_addr),
    .out_wdata  (b_out_wdata),
    .out_accept (b_accept),
    .out_ack    (b_ack),
    .out_error  (b_error),
    .out_rdata  (b_rdata)
  );

  // Stimulus drivers; all called at a falling edge.
  task automatic a_setup(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] st);
    a_paddr = addr; a_pwrite = wr; a_pwdata = wd; a_pstrb = st;
    a_psel = 1'b1; a_penable = 1'b0;
  endtask

  task automatic a_idle();
    a_psel = 1'b0; a_penable = 1'b0; a_accept = 1'b0; a_ack = 1'b0;
    a_error = 1'b0; a_rdata = '0;
  endtask

  task automatic b_idle();
    b_psel = 1'b0; b_penable = 1'b0; b_accept = 1'b0; b_ack = 1'b0;
    b_error = 1'b0; b_rdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_cmp++;
    if ({a_pready, a_pslverr, a_prdata, a_out_wr, a_out_rd, a_out_addr, a_out_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: pready=%0b slverr=%0b prdata=%h wr=%b rd=%0b addr=%h wdata=%h want 0",
               a_pready, a_pslverr, a_prdata, a_out_wr, a_out_rd, a_out_addr, a_out_wdata);
    end
    n_cmp++;
    if ({b_pready, b_pslverr, b_prdata, b_out_wr, b_out_rd, b_out_addr, b_out_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: pready=%0b slverr=%0b prdata=%h wr=%b rd=%0b addr=%h wdata=%h want 0",
               b_pready, b_pslverr, b_prdata, b_out_wr, b_out_rd, b_out_addr, b_out_wdata);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_read();
    a_setup(32'ha000_0010, 1'b0, 32'h0, 4'h0);
    @(negedge clock);  // cycle 1
    a_penable = 1'b1;
    n_cmp++;
    if (a_out_rd !== 1'b1 || a_out_addr !== 32'ha000_0010) begin
      n_bad++;
      $display("FAIL read_req: rd=%0b addr=%h want rd=1 addr=a0000010", a_out_rd, a_out_addr);
    end
    a_accept = 1'b1;
    @(negedge clock);  // cycle 2
    a_accept = 1'b0;
    n_cmp++;
    if (a_out_rd !== 1'b0) begin
      n_bad++; $display("FAIL read_rd_drop: rd=%0b want 0", a_out_rd);
    end
    repeat (2) @(negedge clock);  // cycle 4
    a_ack = 1'b1; a_rdata = 32'hdeadbeef; a_error = 1'b0;
    n_cmp++;
    if (a_pready !== 1'b0) begin
      n_bad++; $display("FAIL read_early_pready: pready=%0b want 0", a_pready);
    end
    @(negedge clock);  // cycle 5
    a_ack = 1'b0; a_rdata = '0;
    n_cmp++;
    if (a_pready !== 1'b1 || a_prdata !== 32'hdeadbeef || a_pslverr !== 1'b0) begin
      n_bad++;
      $display("FAIL read_resp: pready=%0b prdata=%h slverr=%0b want 1 deadbeef 0",
               a_pready, a_prdata, a_pslverr);
    end
    a_idle();
    @(negedge clock);  // cycle 6
    n_cmp++;
    if (a_pready !== 1'b0 || a_prdata !== 32'h0) begin
      n_bad++;
      $display("FAIL read_one_cycle: pready=%0b prdata=%h want 0 0", a_pready, a_prdata);
    end
  endtask

  task automatic test_write();
    a_setup(32'ha000_0004, 1'b1, 32'h1122_3344, 4'b0110);
    @(negedge clock);  // cycle 1, no accept yet
    a_penable = 1'b1;
    n_cmp++;
    if (a_out_wr !== 4'b0110 || a_out_wdata !== 32'h1122_3344 || a_out_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL write_req: wr=%b wdata=%h rd=%0b want 0110 11223344 0",
               a_out_wr, a_out_wdata, a_out_rd);
    end
    @(negedge clock);  // cycle 2
    n_cmp++;
    if (a_out_wr !== 4'b0110) begin
      n_bad++; $display("FAIL write_hold: wr=%b want 0110", a_out_wr);
    end
    a_accept = 1'b1;
    @(negedge clock);  // cycle 3
    a_accept = 1'b0;
    n_cmp++;
    if (a_out_wr !== 4'b0000) begin
      n_bad++; $display("FAIL write_drop: wr=%b want 0000", a_out_wr);
    end
    a_ack = 1'b1; a_error = 1'b1; a_rdata = 32'hffff_ffff;
    @(negedge clock);  // cycle 4
    a_ack = 1'b0; a_error = 1'b0; a_rdata = '0;
    n_cmp++;
    if (a_pready !== 1'b1 || a_pslverr !== 1'b1 || a_prdata !== 32'h0) begin
      n_bad++;
      $display("FAIL write_resp: pready=%0b slverr=%0b prdata=%h want 1 1 0",
               a_pready, a_pslverr, a_prdata);
    end
    a_idle();
    @(negedge clock);
  endtask

  task automatic test_window();
    logic saw_req;
    saw_req = 1'b0;
    a_setup(32'h8000_0000, 1'b1, 32'h5555_aaaa, 4'hf);
    @(negedge clock);  // cycle 1
    a_penable = 1'b1;
    saw_req = saw_req | (a_out_wr != 4'h0) | a_out_rd;
    n_cmp++;
    if (a_pready !== 1'b1 || a_pslverr !== 1'b1) begin
      n_bad++;
      $display("FAIL window_low: pready=%0b slverr=%0b want 1 1", a_pready, a_pslverr);
    end
    a_idle();
    @(negedge clock);
    saw_req = saw_req | (a_out_wr != 4'h0) | a_out_rd;
    // First address past the window end.
    a_setup(32'ha200_0000, 1'b0, 32'h0, 4'h0);
    @(negedge clock);
    a_penable = 1'b1;
    saw_req = saw_req | (a_out_wr != 4'h0) | a_out_rd;
    n_cmp++;
    if (a_pready !== 1'b1 || a_pslverr !== 1'b1) begin
      n_bad++;
      $display("FAIL window_end: pready=%0b slverr=%0b want 1 1", a_pready, a_pslverr);
    end
    a_idle();
    @(negedge clock);
    saw_req = saw_req | (a_out_wr != 4'h0) | a_out_rd;
    n_cmp++;
    if (saw_req !== 1'b0) begin
      n_bad++; $display("FAIL window_no_req: request seen=%0b want 0", saw_req);
    end
  endtask

  task automatic test_zero_strobe();
    a_setup(32'ha000_0008, 1'b1, 32'h1234_5678, 4'h0);
    @(negedge clock);  // cycle 1
    a_penable = 1'b1;
    n_cmp++;
    if (a_pready !== 1'b1 || a_pslverr !== 1'b0 || a_out_wr !== 4'h0) begin
      n_bad++;
      $display("FAIL zero_strobe: pready=%0b slverr=%0b wr=%b want 1 0 0000",
               a_pready, a_pslverr, a_out_wr);
    end
    a_idle();
    @(negedge clock);
  endtask

  task automatic test_timeout();
    logic early;
    a_setup(32'ha000_0020, 1'b0, 32'h0, 4'h0);
    @(negedge clock);  // cycle 1
    a_penable = 1'b1; a_accept = 1'b1;
    @(negedge clock);  // cycle 2
    a_accept = 1'b0;
    early = a_pready;
    repeat (7) begin
      @(negedge clock);  // up to cycle 9
      early = early | a_pready;
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++; $display("FAIL timeout_early: pready seen=%0b want 0", early);
    end
    @(negedge clock);  // cycle 10
    n_cmp++;
    if (a_pready !== 1'b1 || a_pslverr !== 1'b1 || a_prdata !== 32'h0) begin
      n_bad++;
      $display("FAIL timeout_resp: pready=%0b slverr=%0b prdata=%h want 1 1 0",
               a_pready, a_pslverr, a_prdata);
    end
    @(negedge clock);  // cycle 11: next read, must stall in DRAIN
    a_setup(32'ha000_0024, 1'b0, 32'h0, 4'h0);
    @(negedge clock);  // cycle 12
    a_penable = 1'b1;
    n_cmp++;
    if (a_out_rd !== 1'b0 || a_pready !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_stall: rd=%0b pready=%0b want 0 0", a_out_rd, a_pready);
    end
    @(negedge clock);  // cycle 13: late ack
    n_cmp++;
    if (a_out_rd !== 1'b0) begin
      n_bad++; $display("FAIL drain_hold: rd=%0b want 0", a_out_rd);
    end
    a_ack = 1'b1; a_rdata = 32'hbad0_bad0; a_error = 1'b1;
    @(negedge clock);  // cycle 14
    a_ack = 1'b0; a_error = 1'b0;
    n_cmp++;
    if (a_out_rd !== 1'b1 || a_out_addr !== 32'ha000_0024 || a_pready !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_release: rd=%0b addr=%h pready=%0b want 1 a0000024 0",
               a_out_rd, a_out_addr, a_pready);
    end
    a_accept = 1'b1; a_ack = 1'b1; a_rdata = 32'h1234_5678;
    @(negedge clock);  // cycle 15
    a_accept = 1'b0; a_ack = 1'b0;
    n_cmp++;
    if (a_pready !== 1'b1 || a_prdata !== 32'h1234_5678 || a_pslverr !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_resp: pready=%0b prdata=%h slverr=%0b want 1 12345678 0",
               a_pready, a_prdata, a_pslverr);
    end
    a_idle();
    @(negedge clock);
  endtask

  task automatic test_ack_at_expiry();
    a_setup(32'ha000_0030, 1'b0, 32'h0, 4'h0);
    @(negedge clock);  // cycle 1
    a_penable = 1'b1; a_accept = 1'b1;
    @(negedge clock);  // cycle 2
    a_accept = 1'b0;
    repeat (7) @(negedge clock);  // cycle 9 = expiry cycle
    a_ack = 1'b1; a_error = 1'b0; a_rdata = 32'hcafe_f00d;
    @(negedge clock);  // cycle 10
    a_ack = 1'b0; a_rdata = '0;
    n_cmp++;
    if (a_pready !== 1'b1 || a_pslverr !== 1'b0 || a_prdata !== 32'hcafe_f00d) begin
      n_bad++;
      $display("FAIL expiry_ack: pready=%0b slverr=%0b prdata=%h want 1 0 cafef00d",
               a_pready, a_pslverr, a_prdata);
    end
    @(negedge clock);  // cycle 11: nothing pending, so no drain
    a_setup(32'ha000_0034, 1'b0, 32'h0, 4'h0);
    @(negedge clock);
    a_penable = 1'b1;
    n_cmp++;
    if (a_out_rd !== 1'b1) begin
      n_bad++; $display("FAIL expiry_no_pending: rd=%0b want 1", a_out_rd);
    end
    a_accept = 1'b1; a_ack = 1'b1; a_rdata = 32'h55aa_55aa;
    @(negedge clock);
    a_accept = 1'b0; a_ack = 1'b0;
    n_cmp++;
    if (a_pready !== 1'b1 || a_prdata !== 32'h55aa_55aa) begin
      n_bad++;
      $display("FAIL expiry_next: pready=%0b prdata=%h want 1 55aa55aa", a_pready, a_prdata);
    end
    a_idle();
    @(negedge clock);
  endtask

  task automatic test_priv_wide();
    b_paddr = 32'ha000_0010; b_pwrite = 1'b0; b_pprot = 3'b000; b_pstrb = '0; b_pwdata = '0;
    b_psel = 1'b1; b_penable = 1'b0;
    @(negedge clock);
    b_penable = 1'b1;
    n_cmp++;
    if (b_pready !== 1'b1 || b_pslverr !== 1'b1 || b_out_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL priv_reject: pready=%0b slverr=%0b rd=%0b want 1 1 0",
               b_pready, b_pslverr, b_out_rd);
    end
    b_idle();
    @(negedge clock);
    b_paddr = 32'ha000_0013; b_pprot = 3'b001;
    b_psel = 1'b1; b_penable = 1'b0;
    @(negedge clock);
    b_penable = 1'b1;
    n_cmp++;
    if (b_out_rd !== 1'b1 || b_out_addr !== 32'ha000_0010) begin
      n_bad++;
      $display("FAIL wide_addr: rd=%0b addr=%h want 1 a0000010", b_out_rd, b_out_addr);
    end
    b_accept = 1'b1; b_ack = 1'b1; b_rdata = 64'h0123_4567_89ab_cdef;
    @(negedge clock);
    b_accept = 1'b0; b_ack = 1'b0;
    n_cmp++;
    if (b_pready !== 1'b1 || b_prdata !== 64'h0123_4567_89ab_cdef || b_pslverr !== 1'b0) begin
      n_bad++;
      $display("FAIL wide_resp: pready=%0b prdata=%h slverr=%0b want 1 0123456789abcdef 0",
               b_pready, b_prdata, b_pslverr);
    end
    b_idle();
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    a_setup(32'ha000_0040, 1'b0, 32'h0, 4'h0);
    @(negedge clock);  // cycle 1
    a_penable = 1'b1; a_accept = 1'b1;
    @(negedge clock);  // cycle 2, waiting for ack
    a_accept = 1'b0;
    @(negedge clock);  // cycle 3
    reset = 1'b1;
    a_idle();
    @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    if ({a_pready, a_pslverr, a_prdata, a_out_wr, a_out_rd, a_out_addr, a_out_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: pready=%0b slverr=%0b prdata=%h rd=%0b addr=%h want all 0",
               a_pready, a_pslverr, a_prdata, a_out_rd, a_out_addr);
    end
    @(negedge clock);
    a_ack = 1'b1; a_error = 1'b1; a_rdata = 32'hdead_0000;
    @(negedge clock);
    a_ack = 1'b0; a_error = 1'b0; a_rdata = '0;
    n_cmp++;
    if (a_pready !== 1'b0 || a_pslverr !== 1'b0 || a_prdata !== 32'h0) begin
      n_bad++;
      $display("FAIL stray_ack: pready=%0b slverr=%0b prdata=%h want 0 0 0",
               a_pready, a_pslverr, a_prdata);
    end
    a_setup(32'ha000_0044, 1'b0, 32'h0, 4'h0);
    @(negedge clock);
    a_penable = 1'b1;
    n_cmp++;
    if (a_out_rd !== 1'b1 || a_out_addr !== 32'ha000_0044) begin
      n_bad++;
      $display("FAIL post_reset_req: rd=%0b addr=%h want 1 a0000044", a_out_rd, a_out_addr);
    end
    a_accept = 1'b1; a_ack = 1'b1; a_rdata = 32'h600d_600d;
    @(negedge clock);
    a_accept = 1'b0; a_ack = 1'b0;
    n_cmp++;
    if (a_pready !== 1'b1 || a_prdata !== 32'h600d_600d || a_pslverr !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_resp: pready=%0b prdata=%h slverr=%0b want 1 600d600d 0",
               a_pready, a_prdata, a_pslverr);
    end
    a_idle();
    @(negedge clock);
  endtask

  initial begin
    a_paddr = '0; a_pwrite = 1'b0; a_pwdata = '0; a_pstrb = '0; a_pprot = 3'b000;
    b_paddr = '0; b_pwrite = 1'b0; b_pwdata = '0; b_pstrb = '0; b_pprot = 3'b000;
    a_idle();
    b_idle();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    test_reset();
    test_read();
    test_write();
    test_window();
    test_zero_strobe();
    test_timeout();
    test_ack_at_expiry();
    test_priv_wide();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
